pc_ras_unit: RTL and testbench

Parametrised program-counter unit for the processor fetch stage. It generalises the original PC in four ways:
- parametrised address width and reset vector;
- a 4-bit branch-mode field with additional conditions;
- a hardware return-address stack (RAS) for call/return;
- a registered "taken" indicator and a sticky stack-error flag.

It sits between the control unit, the ALU flags and instruction memory. `endereco` drives the instruction-memory address.

---
 rtl/pc_pkg.sv | 38 +++
 rtl/pc_ras.sv | 49 ++++
 rtl/pc_ras_unit.sv | 110 +++++++++++
 tb/tb_pc_ras_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program counter: flow-mode encoding
// and the branch-condition evaluator.
package pc_pkg;

  typedef enum logic [3:0] {
    DESV_SEQ  = 4'd0,
    DESV_JUMP = 4'd1,
    DESV_BEQ  = 4'd2,
    DESV_JR   = 4'd3,
    DESV_BNE  = 4'd4,
    DESV_BLT  = 4'd5,
    DESV_BLE  = 4'd6,
    DESV_BGE  = 4'd7,
    DESV_BGT  = 4'd8,
    DESV_CALL = 4'd9,
    DESV_RET  = 4'd10
  } desvio_t;

  // True when a conditional-branch mode has its condition satisfied by the
  // ALU flags; every non-conditional mode yields 0.
  function automatic logic cond_taken(input desvio_t mode,
                                      input logic    zero,
                                      input logic    negativo);
    logic t;
    t = 1'b0;
    case (mode)
      DESV_BEQ: t = zero;
      DESV_BNE: t = !zero;
      DESV_BLT: t = negativo;
      DESV_BLE: t = negativo | zero;
      DESV_BGE: t = !negativo;
      DESV_BGT: t = !negativo & !zero;
      default:  t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: a RAS_DEPTH x ADDR_W LIFO. dout always shows the
// top entry; pushes on a full stack and pops on an empty one are ignored.
module pc_ras #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     top_idx;

  assign wr_idx  = count[PW-1:0];
  assign top_idx = wr_idx - PW'(1);
  assign full    = (count == CW'(RAS_DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[top_idx];

  // Occupancy counter; reset clears it so no stacked entry survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CW'(1);
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clock) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Fetch-stage program counter with conditional branches, register jumps and
// a hardware return-address stack for call/return.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = {ADDR_W{1'b1}},
  parameter int unsigned       RAS_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stop,
  input  logic [3:0]        desvio,
  input  logic [ADDR_W-1:0] novoEnd,
  input  logic [ADDR_W-1:0] novoEndR,
  input  logic              zero,
  input  logic              negativo,
  output logic [ADDR_W-1:0] endereco,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_err
);

  desvio_t           mode;
  logic [ADDR_W-1:0] seq;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_dout;
  logic              tk_next;
  logic              push_req;
  logic              pop_req;
  logic              err_set;

  assign mode = desvio_t'(desvio);
  assign seq  = endereco + ADDR_W'(1);

  // Next-PC selection; stack over/underflow falls back to the sequential PC.
  always_comb begin
    pc_next  = seq;
    tk_next  = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    err_set  = 1'b0;
    case (mode)
      DESV_JUMP: begin
        pc_next = novoEnd;
        tk_next = 1'b1;
      end
      DESV_JR: begin
        pc_next = novoEndR;
        tk_next = 1'b1;
      end
      DESV_BEQ, DESV_BNE, DESV_BLT, DESV_BLE, DESV_BGE, DESV_BGT: begin
        if (cond_taken(mode, zero, negativo)) begin
          pc_next = novoEnd;
          tk_next = 1'b1;
        end
      end
      DESV_CALL: begin
        if (ras_full) begin
          err_set = 1'b1;
        end else begin
          push_req = 1'b1;
          pc_next  = novoEnd;
          tk_next  = 1'b1;
        end
      end
      DESV_RET: begin
        if (ras_empty) begin
          err_set = 1'b1;
        end else begin
          pop_req = 1'b1;
          pc_next = ras_dout;
          tk_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  pc_ras #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock(clock),
    .reset(reset),
    .push (push_req && !stop),
    .pop  (pop_req && !stop),
    .din  (seq),
    .dout (ras_dout),
    .full (ras_full),
    .empty(ras_empty)
  );

  // PC, taken and sticky error registers; stop freezes all of them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      endereco <= RESET_VEC;
      taken    <= 1'b0;
      ras_err  <= 1'b0;
    end else if (!stop) begin
      endereco <= pc_next;
      taken    <= tk_next;
      if (err_set) begin
        ras_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: sequential flow, conditional branches,
// call/return, stack boundaries, stop, async reset and PC wrap.
module tb_pc_ras_unit;

  localparam int unsigned AW = 32;
  localparam int unsigned D  = 8;

  logic          clock = 1'b0;
  logic          reset;
  logic          stop;
  logic [3:0]    desvio;
  logic [AW-1:0] novoEnd;
  logic [AW-1:0] novoEndR;
  logic          zero;
  logic          negativo;
  logic [AW-1:0] endereco;
  logic          taken;
  logic          ras_empty;
  logic          ras_full;
  logic          ras_err;

  int nvec  = 0;
  int nmiss = 0;

  always #5 clock = ~clock;

  pc_ras_unit #(
    .ADDR_W   (AW),
    .RESET_VEC({AW{1'b1}}),
    .RAS_DEPTH(D)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .stop     (stop),
    .desvio   (desvio),
    .novoEnd  (novoEnd),
    .novoEndR (novoEndR),
    .zero     (zero),
    .negativo (negativo),
    .endereco (endereco),
    .taken    (taken),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .ras_err  (ras_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmiss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] pc_e;
  logic [31:0] stk[$];
  logic [3:0]  modes[6];
  logic [3:0]  truth[6];
  logic        exp_t;
  logic [31:0] tgt;

  initial begin
    // truth[m][{zero,negativo}] = expected branch outcome
    modes = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    truth = '{4'b1100, 4'b0011, 4'b1010, 4'b1110, 4'b0101, 4'b0001};

    reset = 1'b1; stop = 1'b0; desvio = 4'd0;
    novoEnd = '0; novoEndR = '0; zero = 1'b0; negativo = 1'b0;
    #12;
    chk("rst pc", endereco, 32'hFFFF_FFFF);
    chk("rst taken", taken, 0);
    chk("rst empty", ras_empty, 1);
    chk("rst full", ras_full, 0);
    chk("rst err", ras_err, 0);
    reset = 1'b0;

    // sequential fetch, first step wraps to 0
    pc_e = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      step();
      pc_e = pc_e + 1;
      chk("seq pc", endereco, pc_e);
      chk("seq taken", taken, 0);
    end

    // beq taken / not taken
    desvio = 4'd2; zero = 1'b1; novoEnd = 32'h40;
    step();
    chk("beq t pc", endereco, 32'h40);
    chk("beq t taken", taken, 1);
    zero = 1'b0;
    step();
    chk("beq nt pc", endereco, 32'h41);
    chk("beq nt taken", taken, 0);
    pc_e = 32'h41;

    // every conditional mode against all flag combinations
    for (int m = 0; m < 6; m++) begin
      for (int z = 0; z < 2; z++) begin
        for (int n = 0; n < 2; n++) begin
          desvio = modes[m]; zero = z[0]; negativo = n[0]; novoEnd = 32'h200;
          step();
          exp_t = truth[m][z*2+n];
          pc_e  = exp_t ? 32'h200 : pc_e + 1;
          chk($sformatf("cond m%0d z%0d n%0d pc", modes[m], z, n), endereco, pc_e);
          chk($sformatf("cond m%0d z%0d n%0d tk", modes[m], z, n), taken, {31'b0, exp_t});
        end
      end
    end

    // reserved encodings act as sequential
    for (int r = 11; r < 16; r++) begin
      desvio = 4'(r); novoEnd = 32'h999; zero = 1'b1; negativo = 1'b0;
      step();
      pc_e = pc_e + 1;
      chk($sformatf("rsv %0d pc", r), endereco, pc_e);
      chk($sformatf("rsv %0d tk", r), taken, 0);
    end

    // nested call / return
    desvio = 4'd1; novoEnd = 32'h10;
    step();
    chk("jump pc", endereco, 32'h10);
    desvio = 4'd9; novoEnd = 32'h80;
    step();
    chk("call1 pc", endereco, 32'h80);
    chk("call1 empty", ras_empty, 0);
    chk("call1 tk", taken, 1);
    novoEnd = 32'hC0;
    step();
    chk("call2 pc", endereco, 32'hC0);
    desvio = 4'd10;
    step();
    chk("ret1 pc", endereco, 32'h81);
    chk("ret1 tk", taken, 1);
    step();
    chk("ret2 pc", endereco, 32'h11);
    chk("ret2 empty", ras_empty, 1);
    chk("ret2 err", ras_err, 0);
    pc_e = 32'h11;

    // fill the stack, then overflow
    for (int i = 0; i < D; i++) begin
      tgt = 32'h100 + 32'(i) * 32'h10;
      desvio = 4'd9; novoEnd = tgt;
      step();
      stk.push_back(pc_e + 1);
      pc_e = tgt;
      chk($sformatf("fill %0d pc", i), endereco, pc_e);
      chk($sformatf("fill %0d tk", i), taken, 1);
    end
    chk("fill full", ras_full, 1);
    chk("fill err", ras_err, 0);
    novoEnd = 32'h900;
    step();
    pc_e = pc_e + 1;
    chk("ovf pc", endereco, pc_e);
    chk("ovf tk", taken, 0);
    chk("ovf err", ras_err, 1);
    chk("ovf full", ras_full, 1);

    // unwind, then underflow
    desvio = 4'd10;
    for (int i = 0; i < D; i++) begin
      step();
      pc_e = stk.pop_back();
      chk($sformatf("unwind %0d pc", i), endereco, pc_e);
      chk($sformatf("unwind %0d tk", i), taken, 1);
      if (i == 0) chk("unwind full", ras_full, 0);
    end
    chk("unwind empty", ras_empty, 1);
    step();
    pc_e = pc_e + 1;
    chk("udf pc", endereco, pc_e);
    chk("udf tk", taken, 0);
    chk("udf err", ras_err, 1);

    // stop freezes PC, stack and taken
    desvio = 4'd9; novoEnd = 32'h300;
    step();
    stk.push_back(pc_e + 1);
    pc_e = 32'h300;
    chk("pre-stop pc", endereco, pc_e);
    stop = 1'b1; novoEnd = 32'h700;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("stop %0d pc", i), endereco, 32'h300);
      chk($sformatf("stop %0d tk", i), taken, 1);
      chk($sformatf("stop %0d empty", i), ras_empty, 0);
      chk($sformatf("stop %0d full", i), ras_full, 0);
    end
    stop = 1'b0; desvio = 4'd3; novoEndR = 32'h1234;
    step();
    chk("jr pc", endereco, 32'h1234);
    chk("jr tk", taken, 1);
    desvio = 4'd10;
    step();
    pc_e = stk.pop_back();
    chk("post-stop ret pc", endereco, pc_e);
    chk("post-stop empty", ras_empty, 1);
    step();
    chk("post-stop udf pc", endereco, pc_e + 1);
    chk("post-stop udf tk", taken, 0);

    // async reset mid-cycle with three entries stacked
    desvio = 4'd9;
    novoEnd = 32'h400; step();
    novoEnd = 32'h500; step();
    novoEnd = 32'h600; step();
    chk("stack3 pc", endereco, 32'h600);
    chk("stack3 empty", ras_empty, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("async rst pc", endereco, 32'hFFFF_FFFF);
    chk("async rst empty", ras_empty, 1);
    chk("async rst err", ras_err, 0);
    chk("async rst tk", taken, 0);
    step();
    chk("rst hold pc", endereco, 32'hFFFF_FFFF);
    chk("rst hold empty", ras_empty, 1);
    #3;
    reset = 1'b0; desvio = 4'd0;
    step();
    chk("post-rst pc", endereco, 32'h0);

    // wrap from the top of the address space
    desvio = 4'd1; novoEnd = 32'hFFFF_FFFE;
    step();
    chk("wrap jump pc", endereco, 32'hFFFF_FFFE);
    desvio = 4'd0;
    step();
    chk("wrap seq1 pc", endereco, 32'hFFFF_FFFF);
    step();
    chk("wrap seq2 pc", endereco, 32'h0);
    chk("wrap tk", taken, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
